code_ram_arbiter: RTL and testbench

- Shares one single-port, 1-cycle-read-latency RAM between two requesters:
  - the core's instruction fetch port (F, read-only)
  - a data/loader port (D, read/write)
- Data port has priority. A bounded streak counter guarantees fetch progress under sustained D traffic.
- Sits between the core and the RAM model/BRAM. It also gates all grants with the core_control running flag.

---
 rtl/code_ram_arbiter.sv | 83 ++++++++
 tb/tb_code_ram_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/code_ram_arbiter.sv
// Arbitrates a single-port, 1-cycle-latency code RAM between instruction fetch (F)
// and a data/loader port (D). D has priority, bounded by a streak counter so F always progresses.
module code_ram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MAX_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              running,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int SW = $clog2(MAX_STREAK + 1);

  logic [SW-1:0] streak_q, streak_d;
  logic          pend_f_q, pend_d_q;
  logic          grant_en;
  logic          streak_full;

  assign grant_en    = running & ~reset;
  assign streak_full = (streak_q == SW'(MAX_STREAK));

  // D wins unless F is waiting and D has already used up its streak.
  always_comb begin
    d_gnt = grant_en & d_req & (~f_req | ~streak_full);
    f_gnt = grant_en & f_req & ~d_gnt;
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (d_gnt) begin
      ram_addr  = d_addr;
      ram_we    = d_we;
      ram_wdata = d_wdata;
    end else if (f_gnt) begin
      ram_addr  = f_addr;
    end
  end

  // A D grant with F waiting implies streak < MAX_STREAK, so the increment cannot overflow.
  always_comb begin
    streak_d = streak_q;
    if (!f_req || f_gnt) begin
      streak_d = '0;
    end else if (d_gnt && !streak_full) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      streak_q <= '0;
      pend_f_q <= 1'b0;
      pend_d_q <= 1'b0;
    end else begin
      streak_q <= streak_d;
      pend_f_q <= f_gnt;
      pend_d_q <= d_gnt & ~d_we;
    end
  end

  assign f_rvalid = pend_f_q;
  assign d_rvalid = pend_d_q;
  assign rdata    = ram_rdata;

endmodule

// File: tb/tb_code_ram_arbiter.sv
// Table-driven check of code_ram_arbiter against a behavioural 1-cycle-latency RAM,
// plus hand-written reset-in-flight and streak-reset sequences.
module tb_code_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        running = 1'b0;
  logic        f_req = 1'b0;
  logic [15:0] f_addr = '0;
  logic        f_gnt, f_rvalid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [15:0] rdata;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;

  logic [15:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  code_ram_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_STREAK(4)) dut (
    .clock(clock), .reset(reset), .running(running),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Read-first single-port RAM with one cycle of read latency
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0a00 + 16'(i);
  end
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[7:0]];
  end

  typedef struct {
    logic        rst, run, freq;
    logic [15:0] faddr;
    logic        dreq, dwe;
    logic [15:0] daddr, dwdata;
    logic        chk_rv;
    logic        e_fg, e_dg, e_frv, e_drv, e_chk;
    logic [15:0] e_rdata;
    logic        e_we;
    logic [15:0] e_addr, e_wdata;
  } vec_t;

  vec_t tbl [0:63];
  int   n = 0;

  function automatic vec_t mk(input logic rst, run, freq, input logic [15:0] faddr,
                              input logic dreq, dwe, input logic [15:0] daddr, dwdata);
    vec_t v;
    v.rst = rst; v.run = run; v.freq = freq; v.faddr = faddr;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata;
    v.chk_rv = 1'b1;
    v.e_fg = 0; v.e_dg = 0; v.e_frv = 0; v.e_drv = 0; v.e_chk = 0;
    v.e_rdata = '0; v.e_we = 0; v.e_addr = '0; v.e_wdata = '0;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input logic fg, dg, frv, drv, chk,
                              input logic [15:0] rd, input logic we,
                              input logic [15:0] addr, wdata);
    vec_t v = vi;
    v.e_fg = fg; v.e_dg = dg; v.e_frv = frv; v.e_drv = drv; v.e_chk = chk;
    v.e_rdata = rd; v.e_we = we; v.e_addr = addr; v.e_wdata = wdata;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then compare on the falling edge.
  task automatic step(input vec_t v, input int idx);
    @(posedge clock); #1;
    reset = v.rst; running = v.run; f_req = v.freq; f_addr = v.faddr;
    d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwdata;
    @(negedge clock);
    chk("f_gnt", idx, 16'(f_gnt), 16'(v.e_fg));
    chk("d_gnt", idx, 16'(d_gnt), 16'(v.e_dg));
    chk("ram_we", idx, 16'(ram_we), 16'(v.e_we));
    chk("ram_addr", idx, ram_addr, v.e_addr);
    chk("ram_wdata", idx, ram_wdata, v.e_wdata);
    if (v.chk_rv) begin
      chk("f_rvalid", idx, 16'(f_rvalid), 16'(v.e_frv));
      chk("d_rvalid", idx, 16'(d_rvalid), 16'(v.e_drv));
    end
    if (v.e_chk) chk("rdata", idx, rdata, v.e_rdata);
    $display("step %0d: rst=%b run=%b freq=%b dreq=%b dwe=%b -> fg=%b dg=%b frv=%b drv=%b rdata=%h addr=%h",
             idx, v.rst, v.run, v.freq, v.dreq, v.dwe, f_gnt, d_gnt, f_rvalid, d_rvalid, rdata, ram_addr);
  endtask

  initial begin
    vec_t v;
    logic is_f, prev_f, prev_d;

    // Reset then idle
    for (int i = 0; i < 2; i++) begin
      tbl[n] = ex(mk(1, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0); n++;
    end
    // Fetch stream over preloaded words
    for (int i = 0; i < 8; i++) begin
      tbl[n] = ex(mk(0, 1, 1, 16'(i), 0, 0, 0, 0), 1, 0, i > 0, 0, i > 0,
                  16'h0a00 + 16'(i) - 16'd1, 0, 16'(i), 0); n++;
    end
    tbl[n] = ex(mk(0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0, 1, 16'h0a07, 0, 0, 0); n++;
    // Contention: expected D,D,D,D,F repeating
    for (int j = 0; j < 10; j++) begin
      is_f   = (j % 5 == 4);
      prev_f = (j > 0) && (j % 5 == 0);
      prev_d = (j > 0) && !prev_f;
      tbl[n] = ex(mk(0, 1, 1, 16'd5, 1, 0, 16'd2, 16'h1234), is_f, !is_f, prev_f, prev_d, j > 0,
                  prev_f ? 16'h0a05 : 16'h0a02, 0, is_f ? 16'd5 : 16'd2, is_f ? 16'h0 : 16'h1234); n++;
    end
    tbl[n] = ex(mk(0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0, 1, 16'h0a05, 0, 0, 0); n++;
    // Write then read back
    tbl[n] = ex(mk(0, 1, 0, 0, 1, 1, 16'd3, 16'hbeef), 0, 1, 0, 0, 0, 0, 1, 16'd3, 16'hbeef); n++;
    tbl[n] = ex(mk(0, 1, 0, 0, 1, 0, 16'd3, 16'h0), 0, 1, 0, 0, 0, 0, 0, 16'd3, 0); n++;
    tbl[n] = ex(mk(0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 1, 16'hbeef, 0, 0, 0); n++;
    // Running gate
    for (int i = 0; i < 3; i++) begin
      tbl[n] = ex(mk(0, 0, 1, 16'd1, 1, 0, 16'd3, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0); n++;
    end
    tbl[n] = ex(mk(0, 1, 1, 16'd1, 1, 0, 16'd3, 0), 0, 1, 0, 0, 0, 0, 0, 16'd3, 0); n++;
    tbl[n] = ex(mk(0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 1, 16'hbeef, 0, 0, 0); n++;
    // Running drop does not swallow a pending fetch response
    tbl[n] = ex(mk(0, 1, 1, 16'd4, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0, 16'd4, 0); n++;
    tbl[n] = ex(mk(0, 0, 1, 16'd4, 0, 0, 0, 0), 0, 0, 1, 0, 1, 16'h0a04, 0, 0, 0); n++;
    tbl[n] = ex(mk(0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0); n++;

    for (int i = 0; i < n; i++) step(tbl[i], i);

    // Reset in the response cycle discards the fetch response
    step(ex(mk(0, 1, 1, 16'd6, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0, 16'd6, 0), 100);
    v = ex(mk(1, 1, 1, 16'd6, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.chk_rv = 1'b0;
    step(v, 101);
    step(ex(mk(0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0), 102);

    // Build a D streak of 3, reset, then the full D,D,D,D,F pattern must reappear
    for (int j = 0; j < 3; j++)
      step(ex(mk(0, 1, 1, 16'd5, 1, 0, 16'd2, 0), 0, 1, 0, j > 0, j > 0, 16'h0a02, 0, 16'd2, 0), 110 + j);
    v = ex(mk(1, 1, 1, 16'd5, 1, 0, 16'd2, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.chk_rv = 1'b0;
    step(v, 113);
    for (int j = 0; j < 5; j++) begin
      is_f = (j == 4);
      step(ex(mk(0, 1, 1, 16'd5, 1, 0, 16'd2, 0), is_f, !is_f, 0, j > 0, j > 0, 16'h0a02, 0,
              is_f ? 16'd5 : 16'd2, 0), 120 + j);
    end
    step(ex(mk(0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0, 1, 16'h0a05, 0, 0, 0), 125);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
